hqm_rcfwl_gclk_syncgen: RTL
===========================

# hqm_rcfwl_gclk_syncgen

Generates the periodic reference-clock sync pulse that feeds the gclk reference clock distribution stage. The distribution stage uses this pulse to align its div-3 and div-4 dividers. All sync edges fall on a 12-cycle grid, the LCM of 3 and 4, so both divided clocks stay phase-coherent. The block also gives firmware and power-management logic a resync request/ack handshake and a lock indication.

## Interface
- SETTLE_CYC, 64: cycles from enable to the first sync pulse; legal range ≥1.
- SYNC_WIDTH, 2: sync pulse width in cycles; legal range 1..4.
- PERIOD_W, 8: width of period_mult.
- x4clk_in  in  1  sole clock; sync is generated in this domain.
- rst_b  in  1  reset, synchronous, active-low.
- en  in  1  level enable; low forces IDLE.
- period_mult  in  PERIOD_W  periodic sync interval = 12*period_mult cycles; 0 = no periodic sync (initial and requested syncs only).
- resync_req  in  1  level request; held until resync_ack.
- resync_ack  out  1  one-cycle pulse, coincident with the first cycle of the serving sync pulse.
- sync  out  1  registered sync pulse to the distribution stage.
- locked  out  1  high after the first sync pulse completes while enabled.
- sync_cnt  out  8  count of sync pulses issued; wraps 255→0.

## Operation
- Reset (rst_b=0 at a rising edge) clears all outputs: state=IDLE, sync=0, resync_ack=0, locked=0, sync_cnt=0, all counters 0.
- The FSM has four states: IDLE, SETTLE, PULSE, RUN.
- IDLE: en=1 → SETTLE; settle_cnt loaded with SETTLE_CYC-1.
- SETTLE: settle_cnt decrements. At settle_cnt==0 → PULSE.
- PULSE: sync=1 for exactly SYNC_WIDTH cycles.
  - On entry: sync_cnt += 1, grid counter and period counter cleared, period_mult captured into period_reg.
  - On exit: → RUN, locked=1.
- RUN: grid counter counts 0..11 and wraps. Period counter counts cycles since the last pulse start.
  - Periodic sync: when period_reg≠0 and the period counter reaches 12*period_reg-1 → PULSE.
  - Requested sync: resync_req=1 with the grid counter ==11 → PULSE.
- Resync serving rules:
  - Entry into PULSE (from SETTLE or RUN) with resync_req=1 serves the request, and resync_ack pulses in the first PULSE cycle.
  - A request arriving during PULSE is served at a later grid boundary, never by the pulse already in flight.
  - A periodic sync and a resync on the same boundary produce one pulse and one ack; sync_cnt increments by 1.
- en=0 in any state → IDLE at the next edge, including mid-pulse (sync truncated). sync=0 and locked=0. A pending request gets no ack. sync_cnt is held.
- Changes to period_mult mid-period take effect at the next pulse start.
- Arithmetic:
  - The period compare uses PERIOD_W+4 bits and never overflows.
  - Because 12*period_reg ≥ 12 > SYNC_WIDTH, pulses never overlap.

## Timing
- sync, resync_ack and locked are flop outputs with no combinational path from inputs.
- Startup: en sampled high at edge N → sync high from edge N+SETTLE_CYC through edge N+SETTLE_CYC+SYNC_WIDTH. locked rises at edge N+SETTLE_CYC+SYNC_WIDTH.
- Periodic mode: consecutive sync rising edges are exactly 12*period_reg cycles apart.
- Resync: the sync rising edge lands 12*k cycles after the previous rising edge (k≥1), at the first grid boundary where resync_req is sampled high. Worst-case latency is 12 cycles, plus the remainder of any pulse in progress.
- Reset is synchronous: an rst_b assertion mid-pulse drops sync at the same edge.

## Test plan
- Startup: SETTLE_CYC=64, SYNC_WIDTH=2, period_mult=2, en raised at edge 10 → sync high edges 74–76, locked=1 from edge 76, next sync rise at edge 98, sync_cnt=2.
- One-shot: period_mult=0 → exactly one pulse after settle; no further sync over 500 cycles; sync_cnt=1.
- Resync: period_mult=0, resync_req raised 5 cycles after the first pulse start → sync rises 12 cycles after the first rise, resync_ack one cycle at that edge, req dropped → no further pulse.
- Collision: period_mult=1, resync_req held → one pulse every 12 cycles, ack on the first, sync_cnt +1 per pulse (no double count).
- Disable mid-pulse: SYNC_WIDTH=4, en dropped in the 2nd pulse cycle → sync=0 and locked=0 next edge, pending req not acked, sync_cnt held; re-enable repeats the full SETTLE_CYC delay.
- Reset/wrap: 256 pulses with period_mult=1 → sync_cnt wraps to 0. rst_b=0 mid-RUN → all outputs 0 at that edge.

Source files
------------

// File: rtl/hqm_rcfwl_gclk_syncgen.sv
// hqm_rcfwl_gclk_syncgen: 12-cycle-grid reference sync pulse generator with resync handshake and lock flag
module hqm_rcfwl_gclk_syncgen #(
  parameter int SETTLE_CYC = 64,
  parameter int SYNC_WIDTH = 2,
  parameter int PERIOD_W = 8
) (
  input  logic                x4clk_in,
  input  logic                rst_b,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period_mult,
  input  logic                resync_req,
  output logic                resync_ack,
  output logic                sync,
  output logic                locked,
  output logic [7:0]          sync_cnt
);
  localparam int STW = $clog2(SETTLE_CYC + 1);
  localparam int CW = PERIOD_W + 4;
  typedef enum logic [1:0] {IDLE, SETTLE, PULSE, RUN} state_t;
  state_t state, state_n;
  logic [STW-1:0] settle_cnt, settle_cnt_n;
  logic [2:0] pulse_cnt, pulse_cnt_n;
  logic [3:0] grid, grid_n;
  logic [CW-1:0] per_cnt, per_cnt_n, per_last;
  logic [PERIOD_W-1:0] period_reg, period_reg_n;
  logic sync_n, ack_n, locked_n, fire, start;
  logic [7:0] sync_cnt_n;
  // last count of a 12*period_reg-cycle period; period_reg is never 0 when this is used
  assign per_last = (CW'(period_reg) << 3) + (CW'(period_reg) << 2) - CW'(1);
  always_comb begin
    fire = (state == RUN) && ((period_reg != '0 && per_cnt == per_last) || (resync_req && grid == 4'd11));
    start = (state == SETTLE && settle_cnt == '0) || fire;
    state_n = state;
    settle_cnt_n = settle_cnt;
    pulse_cnt_n = pulse_cnt;
    grid_n = (grid == 4'd11) ? 4'd0 : grid + 4'd1;
    per_cnt_n = per_cnt + CW'(1);
    period_reg_n = period_reg;
    sync_n = sync;
    ack_n = 1'b0;
    locked_n = locked;
    sync_cnt_n = sync_cnt;
    if (!en) begin
      state_n = IDLE;
      sync_n = 1'b0;
      locked_n = 1'b0;
      settle_cnt_n = '0;
      pulse_cnt_n = '0;
      grid_n = '0;
      per_cnt_n = '0;
    end else if (start) begin
      state_n = PULSE;
      sync_n = 1'b1;
      ack_n = resync_req;
      sync_cnt_n = sync_cnt + 8'd1;
      pulse_cnt_n = '0;
      grid_n = '0;
      per_cnt_n = '0;
      period_reg_n = period_mult;
    end else begin
      case (state)
        IDLE: begin
          state_n = SETTLE;
          settle_cnt_n = STW'(SETTLE_CYC - 1);
        end
        SETTLE: settle_cnt_n = settle_cnt - STW'(1);
        PULSE: begin
          pulse_cnt_n = pulse_cnt + 3'd1;
          if (pulse_cnt == 3'(SYNC_WIDTH - 1)) begin
            state_n = RUN;
            sync_n = 1'b0;
            locked_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge x4clk_in) begin
    if (!rst_b) begin
      state <= IDLE;
      settle_cnt <= '0;
      pulse_cnt <= '0;
      grid <= '0;
      per_cnt <= '0;
      period_reg <= '0;
      sync <= 1'b0;
      resync_ack <= 1'b0;
      locked <= 1'b0;
      sync_cnt <= '0;
    end else begin
      state <= state_n;
      settle_cnt <= settle_cnt_n;
      pulse_cnt <= pulse_cnt_n;
      grid <= grid_n;
      per_cnt <= per_cnt_n;
      period_reg <= period_reg_n;
      sync <= sync_n;
      resync_ack <= ack_n;
      locked <= locked_n;
      sync_cnt <= sync_cnt_n;
    end
  end
endmodule
